// File: rtl/mmio_bus_decoder_if.sv
// -----------------------------------------------------------------------------
// mmio_bus_decoder_if
//
// Bundles the load/store port of the core, the per-slave strobes and
// ready/data returns, and the decoder's status outputs into one interface.
//
//   modport master : the core and slave side, which drives the request
//                    (address, memRead, memWrite) and the slave responses
//                    (slave_ready, slave_rdata), and observes the decoder.
//   modport slave  : the decoder, which consumes the request and responses
//                    and drives strobes, rd_sel, rdata, rd_valid, stall,
//                    bus_err and err_addr.
// -----------------------------------------------------------------------------
interface mmio_bus_decoder_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_SLAVES = 3
);
    localparam int SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [WIDTH-1:0]            address;
    logic                        memRead;
    logic                        memWrite;
    logic [NUM_SLAVES-1:0]       slave_ready;
    logic [NUM_SLAVES*WIDTH-1:0] slave_rdata;
    logic [NUM_SLAVES-1:0]       we;
    logic [NUM_SLAVES-1:0]       re;
    logic [SELW-1:0]             rd_sel;
    logic [WIDTH-1:0]            rdata;
    logic                        rd_valid;
    logic                        stall;
    logic                        bus_err;
    logic [WIDTH-1:0]            err_addr;

    modport master (
        output address, memRead, memWrite, slave_ready, slave_rdata,
        input  we, re, rd_sel, rdata, rd_valid, stall, bus_err, err_addr
    );

    modport slave (
        input  address, memRead, memWrite, slave_ready, slave_rdata,
        output we, re, rd_sel, rdata, rd_valid, stall, bus_err, err_addr
    );
endinterface

// File: rtl/mmio_bus_decoder.sv
// -----------------------------------------------------------------------------
// mmio_bus_decoder
//
// Decodes a core load/store into one of NUM_SLAVES address windows, holds a
// one-hot write or read strobe on the selected slave until it reports ready,
// and stalls the core meanwhile. Unmapped addresses and slaves that do not
// answer within TIMEOUT cycles end in a one-cycle bus error.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mmio_bus_decoder_if.slave
//            in  address, memRead, memWrite, slave_ready, slave_rdata
//            out we, re (one-hot strobes), rd_sel, rdata, rd_valid,
//                stall, bus_err, err_addr
// -----------------------------------------------------------------------------
module mmio_bus_decoder #(
    parameter int               WIDTH      = 32,
    parameter int               NUM_SLAVES = 3,
    parameter int               SEL_LO     = 10,
    parameter int               TIMEOUT    = 15,
    parameter logic [WIDTH-1:0] ERR_DATA   = WIDTH'(32'hDEAD_BEEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    mmio_bus_decoder_if.slave bus
);
    localparam int SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // The counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST     = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SELW:0]   NUM_SLAVES_W = (SELW + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [SELW-1:0]       sel_q;
    logic [WIDTH-1:0]      addr_q;
    logic                  op_write_q;
    logic [CNTW-1:0]       cnt_q;
    logic [NUM_SLAVES-1:0] we_q, re_q;
    logic [WIDTH-1:0]      rdata_q;
    logic [WIDTH-1:0]      err_addr_q;

    logic                  req;
    logic [SELW-1:0]       idx;
    logic                  mapped;
    logic [NUM_SLAVES-1:0] idx_onehot;
    logic                  sel_ready;
    logic [WIDTH-1:0]      sel_rdata;
    logic                  timed_out;

    // ------------------------------------------------------------------
    // Address decode and selected-slave muxing
    // ------------------------------------------------------------------
    assign req = bus.memRead | bus.memWrite;
    assign idx = bus.address[SEL_LO +: SELW];
    // A shift instead of a part-select keeps this legal when the select
    // field reaches the top of the address.
    assign mapped = ({1'b0, idx} < NUM_SLAVES_W) &&
                    ((bus.address >> (SEL_LO + SELW)) == '0);

    // Only the latched selection is looked at, so ready bits of other
    // slaves cannot complete the access.
    assign sel_ready = bus.slave_ready[sel_q];
    assign sel_rdata = bus.slave_rdata[int'(sel_q) * WIDTH +: WIDTH];
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every bit is assigned before any condition; a path that
        // leaves a combinational output unassigned would infer a latch.
        idx_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            idx_onehot[i] = (idx == SELW'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment for all sequential state, so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = mapped ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                // Ready beats the timeout when both happen in the same cycle.
                if (sel_ready) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: strobes, selection, counter, read data, error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, not only the state:
            // rdata, rd_sel and err_addr are visible to the core right after
            // reset and must read as zero.
            sel_q      <= '0;
            addr_q     <= '0;
            op_write_q <= 1'b0;
            cnt_q      <= '0;
            we_q       <= '0;
            re_q       <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        // memWrite wins when both request lines are high.
                        op_write_q <= bus.memWrite;
                        cnt_q      <= '0;
                        if (mapped) begin
                            sel_q  <= idx;
                            addr_q <= bus.address;
                            we_q   <= bus.memWrite ? idx_onehot : '0;
                            re_q   <= bus.memWrite ? '0 : idx_onehot;
                        end else begin
                            err_addr_q <= bus.address;
                            rdata_q    <= ERR_DATA;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        we_q <= '0;
                        re_q <= '0;
                        if (!op_write_q) begin
                            rdata_q <= sel_rdata;
                        end
                    end else if (timed_out) begin
                        we_q <= '0;
                        re_q <= '0;
                        // The address seen in IDLE, not whatever the core
                        // drives now.
                        err_addr_q <= addr_q;
                        rdata_q    <= ERR_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.we       = we_q;
    assign bus.re       = re_q;
    assign bus.rd_sel   = sel_q;
    assign bus.rdata    = rdata_q;
    assign bus.err_addr = err_addr_q;
    assign bus.bus_err  = (state_q == ERR);
    assign bus.rd_valid = ((state_q == DONE) || (state_q == ERR)) && !op_write_q;
    // Gated by rst_n so the core is released the instant reset asserts,
    // even with a request pending.
    assign bus.stall    = rst_n && (((state_q == IDLE) && req) || (state_q == ACCESS));

endmodule

// File: doc/mmio_bus_decoder.md
# mmio_bus_decoder

Parametrised memory-mapped bus decoder with a wait-state handshake, sitting between the RISC-V core's load/store port and its memory-mapped slaves: data memory, UART and further peripherals. It decodes the access address into one of `NUM_SLAVES` windows and drives a held write or read strobe to the selected slave. It stalls the core until the slave signals ready, then returns registered read data. Unmapped addresses and unresponsive slaves are terminated with a bus-error pulse instead of hanging the core.

## Interface
Parameters:
- `WIDTH`, 32, address and data width.
- `NUM_SLAVES`, 3, number of decoded windows (1..16).
- `SEL_LO`, 10, lowest address bit of the slave-select field.
- `TIMEOUT`, 15, maximum wait cycles in ACCESS before error; 0 disables the timeout.
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on error.
- Localparam `SELW` = max(1, clog2(NUM_SLAVES)).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `address` in WIDTH: byte address from the core.
- `memRead` in 1: load request.
- `memWrite` in 1: store request.
- `slave_ready` in NUM_SLAVES: per-slave completion.
- `slave_rdata` in NUM_SLAVES*WIDTH: slave i data at `[i*WIDTH +: WIDTH]`.
- `we` out NUM_SLAVES: one-hot write strobe.
- `re` out NUM_SLAVES: one-hot read strobe.
- `rd_sel` out SELW: index of the current or last slave.
- `rdata` out WIDTH: registered read data to the core.
- `rd_valid` out 1: `rdata` valid (DONE state of a read).
- `stall` out 1: hold the core's PC and pipeline.
- `bus_err` out 1: one-cycle error pulse.
- `err_addr` out WIDTH: address of the last faulting access.

## Operation
- Request: `req` = `memRead | memWrite`. When both are high, the access is a write (`memWrite` has priority).
- Decode: `idx` = `address[SEL_LO +: SELW]`. The access is mapped iff `idx < NUM_SLAVES` and `address[WIDTH-1:SEL_LO+SELW]` == 0.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - `req` and mapped: latch `idx` into `rd_sel`, latch op, clear the wait counter, go to ACCESS.
  - `req` and unmapped: latch `address` into `err_addr`, go to ERR.
  - No `req`: stay in IDLE.
- ACCESS:
  - Exactly one of `we[rd_sel]`/`re[rd_sel]` is high, registered, for the whole state; all other strobe bits are 0.
  - `slave_ready[rd_sel]` sampled high: for reads, `rdata` <= `slave_rdata[rd_sel]`; go to DONE.
  - Otherwise, if `TIMEOUT`≠0 and counter == `TIMEOUT`-1: latch the address into `err_addr`, go to ERR.
  - Otherwise increment the counter.
  - Ready bits of non-selected slaves are ignored.
- DONE: strobes 0; `rd_valid` = 1 for reads; the core commits this cycle; next state IDLE.
- ERR: strobes 0; `bus_err` = 1; `rdata` = `ERR_DATA`; `rd_valid` = 1 for reads; next state IDLE.
- `stall` = (IDLE & `req`) | ACCESS, combinational; it is 0 in DONE and ERR.
- `rd_sel` and `err_addr` hold their values until the next capture.

## Timing
- Reset (asynchronous, `rst_n` low): state IDLE, `we`=0, `re`=0, `rd_sel`=0, `rdata`=0, `rd_valid`=0, `bus_err`=0, `err_addr`=0, counter 0. `stall` is forced 0 while `rst_n` is low.
- Reset mid-access drops the strobes immediately. After release the core re-issues the access from IDLE.
- Mapped access latency: request cycle (IDLE) + k ACCESS cycles (k ≥ 1; ready in the first ACCESS cycle gives k=1) + 1 DONE cycle. The minimum is therefore 3 cycles with `stall` high for 2.
- Timeout: the ERR cycle follows exactly `TIMEOUT` ACCESS cycles without ready. Ready sampled in the same cycle the counter hits its limit wins, and the state goes to DONE.
- Unmapped access: request cycle then ERR, i.e. 2 cycles with `stall` high for 1.
- Back-to-back requests: the first IDLE cycle after DONE or ERR accepts a new request; there is no idle gap beyond that.
- Address and op are sampled only in IDLE. Changes to `address`, `memRead` or `memWrite` during ACCESS are ignored.

## Test plan
- Write, NUM_SLAVES=3, SEL_LO=10: `memWrite`=1, address 0x404, `slave_ready[1]`=1 immediately. Required: `we`=3'b010 for 1 cycle, `stall` high 2 cycles, no `bus_err`.
- Read with wait states: address 0x800, `slave_ready[2]` rises after 3 ACCESS cycles, `slave_rdata[2]`=0x1234_5678. Required: `re`=3'b100 for 3 cycles, then DONE with `rdata`=0x1234_5678 and `rd_valid`=1.
- Unmapped access: address 0xC00, then 0x1000. Each gives `bus_err` 1-cycle pulse, `err_addr` = that address, no strobe; a read returns `rdata`=0xDEAD_BEEF.
- Timeout: TIMEOUT=15, slave 0 never ready. Required: `re[0]` high for exactly 15 cycles, then `bus_err` pulse. Variant with ready arriving on cycle 15 → DONE, no error.
- Priority and isolation: `memRead`=`memWrite`=1 at 0x000 produces a write only. `slave_ready[2]` asserted during an access to slave 0 has no effect.
- Reset: `rst_n` pulled low in ACCESS (asynchronously, mid-cycle) forces strobes and `stall` to 0 at once. After release all outputs are at their reset values and a new request proceeds normally.
